// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_mem_stage_if                                                            |
// | Execute-side, data-memory and write-back signal bundle for ex_mem_stage.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic              ex_zero;
  logic [DATA_W-1:0] ex_add_result;
  logic [DATA_W-1:0] ex_read_data_2;
  logic [REG_W-1:0]  ex_rd_or_rt;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic              stall;
  logic              pc_src;
  logic [DATA_W-1:0] branch_target;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport slave (
    input  ex_valid, ex_alu_result, ex_zero, ex_add_result, ex_read_data_2,
           ex_rd_or_rt, ex_mem_read, ex_mem_write, ex_branch, ex_reg_write,
           ex_mem_to_reg, dmem_ack, dmem_rdata,
    output stall, pc_src, branch_target, dmem_req, dmem_we, dmem_addr,
           dmem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data
  );

  modport master (
    output ex_valid, ex_alu_result, ex_zero, ex_add_result, ex_read_data_2,
           ex_rd_or_rt, ex_mem_read, ex_mem_write, ex_branch, ex_reg_write,
           ex_mem_to_reg, dmem_ack, dmem_rdata,
    input  stall, pc_src, branch_target, dmem_req, dmem_we, dmem_addr,
           dmem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_mem_stage                                                               |
// | EX/MEM pipeline register, branch resolve and req/ack data-memory access.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  ex_mem_stage_if.slave bus
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // EX/MEM register
  logic              r_valid;
  logic              r_zero;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_branch;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_add_result;
  logic [DATA_W-1:0] r_read_data_2;
  logic [REG_W-1:0]  r_rd;

  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [DATA_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;

  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic [REG_W-1:0]  r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;

  logic w_stall;
  logic w_launch;
  logic w_complete;
  logic w_in_mem;
  logic w_ex_is_mem;
  logic w_pass_through;
  logic w_wb_we;

  // A branch never touches memory, even if its mem bits are set.
  assign w_in_mem    = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write) & ~bus.ex_branch;
  assign w_ex_is_mem = r_valid & (r_mem_read | r_mem_write) & ~r_branch;

  // A held memory instruction has already retired through the ack path.
  assign w_pass_through = ~w_stall & r_valid & ~w_ex_is_mem;
  assign w_wb_we        = r_reg_write & ~r_mem_write & ~r_branch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_launch    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_in_mem) begin
          w_state_nxt = ST_MEM_WAIT;
          w_launch    = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        w_stall = 1'b1;
        if (bus.dmem_ack) begin
          w_state_nxt = ST_RUN;
          w_complete  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_zero        <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_result  <= '0;
      r_add_result  <= '0;
      r_read_data_2 <= '0;
      r_rd          <= '0;
    end else if (!w_stall) begin
      r_valid       <= bus.ex_valid;
      r_zero        <= bus.ex_valid & bus.ex_zero;
      r_mem_read    <= bus.ex_valid & bus.ex_mem_read;
      r_mem_write   <= bus.ex_valid & bus.ex_mem_write;
      r_branch      <= bus.ex_valid & bus.ex_branch;
      r_reg_write   <= bus.ex_valid & bus.ex_reg_write;
      r_mem_to_reg  <= bus.ex_valid & bus.ex_mem_to_reg;
      r_alu_result  <= bus.ex_alu_result;
      r_add_result  <= bus.ex_add_result;
      r_read_data_2 <= bus.ex_read_data_2;
      r_rd          <= bus.ex_rd_or_rt;
    end
  end

  // Request fields are loaded straight from the inputs so req rises with the capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else if (w_launch) begin
      r_dmem_req   <= 1'b1;
      r_dmem_we    <= bus.ex_mem_write;
      r_dmem_addr  <= {bus.ex_alu_result[DATA_W-1:2], 2'b00};
      r_dmem_wdata <= bus.ex_read_data_2;
    end else if (w_complete) begin
      r_dmem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
    end else begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      if (w_complete) begin
        r_wb_valid     <= 1'b1;
        r_wb_reg_write <= w_wb_we;
        r_wb_rd        <= r_rd;
        r_wb_data      <= r_mem_to_reg ? bus.dmem_rdata : r_alu_result;
      end else if (w_pass_through) begin
        r_wb_valid     <= 1'b1;
        r_wb_reg_write <= w_wb_we;
        r_wb_rd        <= r_rd;
        r_wb_data      <= r_alu_result;
      end
    end
  end

  assign bus.stall         = w_stall;
  assign bus.pc_src        = r_valid & r_branch & r_zero;
  assign bus.branch_target = r_add_result;
  assign bus.dmem_req      = r_dmem_req;
  assign bus.dmem_we       = r_dmem_we;
  assign bus.dmem_addr     = r_dmem_addr;
  assign bus.dmem_wdata    = r_dmem_wdata;
  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_reg_write  = r_wb_reg_write;
  assign bus.wb_rd         = r_wb_rd;
  assign bus.wb_data       = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ex_mem_stage                                                            |
// | Self-checking bench: directed cases plus randomized traffic vs a model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ex_mem_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct {
    logic        valid, zero, mr, mw, br, rw, mtr;
    logic [31:0] alu, add, rd2;
    logic [4:0]  rd;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();
  ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t i;
    i.valid = 0; i.zero = 0; i.mr = 0; i.mw = 0; i.br = 0; i.rw = 0; i.mtr = 0;
    i.alu = '0; i.add = '0; i.rd2 = '0; i.rd = '0;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus.ex_valid       = i.valid;
    bus.ex_zero        = i.zero;
    bus.ex_mem_read    = i.mr;
    bus.ex_mem_write   = i.mw;
    bus.ex_branch      = i.br;
    bus.ex_reg_write   = i.rw;
    bus.ex_mem_to_reg  = i.mtr;
    bus.ex_alu_result  = i.alu;
    bus.ex_add_result  = i.add;
    bus.ex_read_data_2 = i.rd2;
    bus.ex_rd_or_rt    = i.rd;
  endtask

  // ---------------- memory responder (auto) / manual ack ----------------
  logic        auto_mode = 1'b0;
  logic        man_ack   = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        a_ack     = 1'b0;
  logic [31:0] a_rdata   = '0;
  int          a_cnt     = 0;
  logic [31:0] mem [logic [31:0]];

  assign bus.dmem_ack   = auto_mode ? a_ack   : man_ack;
  assign bus.dmem_rdata = auto_mode ? a_rdata : man_rdata;

  always @(posedge clk) begin
    #1;
    if (rst || !auto_mode) begin
      a_cnt = 0;
      a_ack = 1'b0;
    end else if (a_ack) begin
      a_ack = 1'b0;
    end else if (bus.dmem_req) begin
      if (a_cnt == 0) a_cnt = int'($urandom_range(1, 4));
      a_cnt--;
      if (a_cnt == 0) begin
        a_ack = 1'b1;
        if (bus.dmem_we) begin
          mem[bus.dmem_addr] = bus.dmem_wdata;
          a_rdata = $urandom;
        end else begin
          a_rdata = mem.exists(bus.dmem_addr) ? mem[bus.dmem_addr]
                                              : (~bus.dmem_addr ^ 32'hA5A5_0000);
        end
      end
    end else if ($urandom_range(0, 15) == 0) begin
      a_ack   = 1'b1;        // stray ack while idle must be ignored
      a_rdata = $urandom;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  instr_t      m_ex;
  logic        m_busy;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_wbv, m_wbw;
  logic [4:0]  m_wbrd;
  logic [31:0] m_wbd;
  int          n_accepted = 0;

  function automatic logic needs_mem(input instr_t i);
    return i.valid && (i.mr || i.mw) && !i.br;
  endfunction

  function automatic instr_t sample_inputs();
    instr_t i;
    i.valid = bus.ex_valid;     i.zero = bus.ex_zero;
    i.mr    = bus.ex_mem_read;  i.mw   = bus.ex_mem_write;
    i.br    = bus.ex_branch;    i.rw   = bus.ex_reg_write;
    i.mtr   = bus.ex_mem_to_reg;
    i.alu   = bus.ex_alu_result; i.add = bus.ex_add_result;
    i.rd2   = bus.ex_read_data_2; i.rd = bus.ex_rd_or_rt;
    if (!i.valid) i = bubble();
    return i;
  endfunction

  task automatic retire(input instr_t i, input logic [31:0] rdata);
    m_wbv  = 1'b1;
    m_wbw  = i.rw && !i.mw && !i.br;
    m_wbrd = i.rd;
    m_wbd  = i.mtr ? rdata : i.alu;
  endtask

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_ex = bubble(); m_busy = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_wbv = 0; m_wbw = 0; m_wbrd = '0; m_wbd = '0;
    end else begin
      chk("stall",    32'(bus.stall),    32'(m_busy));
      chk("dmem_req", 32'(bus.dmem_req), 32'(m_busy));
      chk("pc_src",   32'(bus.pc_src),   32'(m_ex.valid & m_ex.br & m_ex.zero));
      if (m_ex.valid && m_ex.br && m_ex.zero) chk("branch_target", bus.branch_target, m_ex.add);
      if (m_busy) begin
        chk("dmem_we",   32'(bus.dmem_we), 32'(m_we));
        chk("dmem_addr", bus.dmem_addr,    m_addr);
        if (m_we) chk("dmem_wdata", bus.dmem_wdata, m_wdata);
      end
      chk("wb_valid",     32'(bus.wb_valid),     32'(m_wbv));
      chk("wb_reg_write", 32'(bus.wb_reg_write), 32'(m_wbw));
      if (m_wbv) begin
        chk("wb_rd",   32'(bus.wb_rd), 32'(m_wbrd));
        chk("wb_data", bus.wb_data,    m_wbd);
      end
      // what the coming edge must produce
      m_wbv = 0; m_wbw = 0;
      if (m_busy) begin
        if (bus.dmem_ack) begin
          m_busy = 0;
          retire(m_ex, bus.dmem_rdata);
        end
      end else begin
        if (m_ex.valid && !needs_mem(m_ex)) retire(m_ex, 32'h0);
        m_ex = sample_inputs();
        if (m_ex.valid) n_accepted++;
        if (needs_mem(m_ex)) begin
          m_busy  = 1;
          m_we    = m_ex.mw;
          m_addr  = m_ex.alu & ~32'h3;
          m_wdata = m_ex.rd2;
        end
      end
    end
  end

  // ---------------- activity monitor ----------------
  int          req_rises = 0;
  int          wb_pulses = 0;
  logic        prev_req  = 1'b0;
  logic [31:0] wb_log [$];

  always @(negedge clk) begin
    if (bus.dmem_req && !prev_req) req_rises++;
    prev_req = bus.dmem_req;
    if (bus.wb_valid) begin
      wb_pulses++;
      wb_log.push_back(bus.wb_data);
    end
  end

  // ---------------- upstream helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input instr_t i);
    logic taken;
    int   guard;
    drive(i);
    taken = 0;
    guard = 0;
    while (!taken && guard < 50) begin
      @(negedge clk);
      taken = !bus.stall;
      step();
      guard++;
    end
    n_tests++;
    if (!taken) begin
      n_fail++;
      $display("FAIL issue_timeout: got stalled expected accepted within 50 cycles");
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    drive(bubble());
    while (bus.stall && g < 30) begin
      step();
      g++;
    end
    chk("drain_stall", 32'(bus.stall), 32'h0);
    repeat (2) step();
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i = bubble();
    i.valid = 1;
    i.zero  = 1'($urandom);
    i.alu   = 32'h1000 + ($urandom % 64);
    i.add   = $urandom;
    i.rd2   = $urandom;
    i.rd    = 5'($urandom);
    case ($urandom_range(0, 5))
      0: begin i.rw = 1; i.alu = $urandom; end
      1: begin i.mr = 1; i.mtr = 1; i.rw = 1; end
      2: i.mw = 1;
      3: i.br = 1;
      4: begin i.mr = 1; i.mw = 1; end
      default: begin i.br = 1; i.mr = 1; end
    endcase
    return i;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    instr_t t;
    int     base_req, base_wb, base_acc;

    drive(bubble());
    repeat (2) step();
    chk("reset_stall",    32'(bus.stall),        32'h0);
    chk("reset_dmem_req", 32'(bus.dmem_req),     32'h0);
    chk("reset_wb_valid", 32'(bus.wb_valid),     32'h0);
    chk("reset_pc_src",   32'(bus.pc_src),       32'h0);
    chk("reset_wb_we",    32'(bus.wb_reg_write), 32'h0);
    rst = 1'b0;
    step();

    // ALU op
    t = bubble(); t.valid = 1; t.alu = 32'h10; t.rd = 5'd5; t.rw = 1;
    drive(t); step();
    chk("alu_stall", 32'(bus.stall), 32'h0);
    drive(bubble()); step();
    chk("alu_wb_valid", 32'(bus.wb_valid), 32'h1);
    chk("alu_wb_rd",    32'(bus.wb_rd),    32'h5);
    chk("alu_wb_data",  bus.wb_data,       32'h10);
    chk("alu_wb_we",    32'(bus.wb_reg_write), 32'h1);

    // Load, ack three cycles after req
    t = bubble(); t.valid = 1; t.mr = 1; t.mtr = 1; t.rw = 1; t.alu = 32'h100; t.rd = 5'd7;
    drive(t); step();
    for (int c = 0; c < 3; c++) begin
      chk("ld_req",   32'(bus.dmem_req), 32'h1);
      chk("ld_stall", 32'(bus.stall),    32'h1);
      chk("ld_we",    32'(bus.dmem_we),  32'h0);
      chk("ld_addr",  bus.dmem_addr,     32'h100);
      if (c == 2) begin man_ack = 1; man_rdata = 32'hDEAD_BEEF; end
      step();
    end
    man_ack = 0;
    drive(bubble());
    chk("ld_wb_valid", 32'(bus.wb_valid),     32'h1);
    chk("ld_wb_data",  bus.wb_data,           32'hDEAD_BEEF);
    chk("ld_wb_we",    32'(bus.wb_reg_write), 32'h1);
    chk("ld_done_req", 32'(bus.dmem_req),     32'h0);
    step();

    // Store, ack on the first wait cycle
    t = bubble(); t.valid = 1; t.mw = 1; t.alu = 32'h203; t.rd2 = 32'hCAFE_0001;
    drive(t); step();
    chk("st_addr",  bus.dmem_addr,     32'h200);
    chk("st_we",    32'(bus.dmem_we),  32'h1);
    chk("st_wdata", bus.dmem_wdata,    32'hCAFE_0001);
    chk("st_stall", 32'(bus.stall),    32'h1);
    man_ack = 1;
    step();
    man_ack = 0;
    drive(bubble());
    chk("st_wb_valid", 32'(bus.wb_valid),     32'h1);
    chk("st_wb_we",    32'(bus.wb_reg_write), 32'h0);
    chk("st_stall_end", 32'(bus.stall),       32'h0);
    step();

    // Branch taken / not taken
    t = bubble(); t.valid = 1; t.br = 1; t.zero = 1; t.add = 32'h40;
    drive(t); step();
    chk("br_pc_src", 32'(bus.pc_src),   32'h1);
    chk("br_target", bus.branch_target, 32'h40);
    chk("br_no_req", 32'(bus.dmem_req), 32'h0);
    t.zero = 0;
    drive(t); step();
    chk("br_nt_pc_src", 32'(bus.pc_src),   32'h0);
    chk("br_nt_no_req", 32'(bus.dmem_req), 32'h0);
    drive(bubble()); step();

    // Reset while waiting on memory, then a late ack
    t = bubble(); t.valid = 1; t.mr = 1; t.mtr = 1; t.rw = 1; t.alu = 32'h140; t.rd = 5'd9;
    drive(t); step();
    chk("rst_pre_req", 32'(bus.dmem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req",   32'(bus.dmem_req), 32'h0);
    chk("rst_async_stall", 32'(bus.stall),    32'h0);
    drive(bubble());
    step();
    rst = 1'b0;
    man_ack = 1; man_rdata = 32'h1234_5678;
    step();
    man_ack = 0;
    chk("late_ack_wb_valid", 32'(bus.wb_valid), 32'h0);
    chk("late_ack_stall",    32'(bus.stall),    32'h0);
    step();
    chk("late_ack_wb_valid2", 32'(bus.wb_valid), 32'h0);

    // Back-to-back loads with inputs held under stall
    auto_mode = 1;
    base_req = req_rises;
    base_wb  = wb_pulses;
    t = bubble(); t.valid = 1; t.mr = 1; t.mtr = 1; t.rw = 1; t.alu = 32'h300; t.rd = 5'd1;
    issue(t);
    t.alu = 32'h306; t.rd = 5'd2;
    issue(t);
    drain();
    chk("b2b_req_count", 32'(req_rises - base_req), 32'h2);
    chk("b2b_wb_count",  32'(wb_pulses - base_wb),  32'h2);
    if (wb_log.size() >= 2) begin
      chk("b2b_first_data",  wb_log[wb_log.size()-2], 32'h5A5A_FCFF);
      chk("b2b_second_data", wb_log[wb_log.size()-1], 32'h5A5A_FCFB);
    end else begin
      chk("b2b_log_size", 32'(wb_log.size()), 32'h2);
    end

    // Randomized traffic
    base_wb  = wb_pulses;
    base_acc = n_accepted;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(bubble());
        step();
      end else begin
        issue(rand_instr());
      end
    end
    drain();
    chk("rand_wb_total", 32'(wb_pulses - base_wb), 32'(n_accepted - base_acc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
